// File: rtl/io_bus_pkg.sv
// Shared state encoding and default timing constants for the external IO bus controller.
package io_bus_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_SETUP_CYCLES   = 1;
  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_STROBE = 2'd2,
    BUS_HOLD   = 2'd3
  } bus_state_e;

  // Strobe counter must be able to hold TIMEOUT_CYCLES itself without wrapping.
  function automatic int strobe_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module io_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/io_bus_controller.sv
// Strobed external IO bus master: SETUP / STROBE / HOLD cycle sequencing with
// ready-extended strobes, timeout termination and registered, glitch-free bus controls.
module io_bus_controller
  import io_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] a_bus,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  protocol_err,
  output logic [ADDR_WIDTH-1:0] out_address,
  inout  wire  [DATA_WIDTH-1:0] inout_data,
  output logic                  out_rd_n,
  output logic                  out_wr_n,
  input  logic                  ext_ready
);

  localparam int CNT_W = strobe_cnt_width(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = BUS_IDLE;
  localparam logic [1:0] SETUP  = BUS_SETUP;
  localparam logic [1:0] STROBE = BUS_STROBE;
  localparam logic [1:0] HOLD   = BUS_HOLD;

  localparam logic [3:0]       SETUP_LIM   = 4'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LIM  = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]            state_reg, state_next;
  logic [3:0]            setup_cnt_reg, setup_cnt_next;
  logic [CNT_W-1:0]      strobe_cnt_reg, strobe_cnt_next;
  logic                  dir_wr_reg, dir_wr_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rd_data_reg, rd_data_next;
  logic                  addr_oe_reg, addr_oe_next;
  logic                  data_oe_reg, data_oe_next;
  logic                  rd_n_reg, rd_n_next;
  logic                  wr_n_reg, wr_n_next;
  logic                  done_reg, done_next;
  logic                  timeout_reg, timeout_next;
  logic                  perr_reg, perr_next;

  logic ready_sync;
  logic ready_exit;
  logic limit_exit;

  io_sync2 u_ready_sync (
    .clk (clock),
    .rst (reset),
    .d   (ext_ready),
    .q   (ready_sync)
  );

  // A ready device wins over the timeout when both land on the same count.
  assign ready_exit = (strobe_cnt_reg >= STROBE_LIM) && ready_sync;
  assign limit_exit = (strobe_cnt_reg == TIMEOUT_LIM);

  always_comb begin
    state_next      = state_reg;
    setup_cnt_next  = setup_cnt_reg;
    strobe_cnt_next = strobe_cnt_reg;
    dir_wr_next     = dir_wr_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rd_data_next    = rd_data_reg;
    addr_oe_next    = addr_oe_reg;
    data_oe_next    = data_oe_reg;
    rd_n_next       = rd_n_reg;
    wr_n_next       = wr_n_reg;
    done_next       = 1'b0;
    timeout_next    = 1'b0;
    perr_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rd ^ wr) begin
          state_next     = SETUP;
          dir_wr_next    = wr;
          addr_next      = a_bus;
          wdata_next     = wr_data;
          setup_cnt_next = 4'd1;
          addr_oe_next   = 1'b1;
          data_oe_next   = wr;
        end else if (rd && wr) begin
          perr_next = 1'b1;
        end
      end

      SETUP: begin
        if (setup_cnt_reg >= SETUP_LIM) begin
          state_next      = STROBE;
          strobe_cnt_next = CNT_ONE;
          rd_n_next       = dir_wr_reg;
          wr_n_next       = !dir_wr_reg;
        end else begin
          setup_cnt_next = setup_cnt_reg + 4'd1;
        end
      end

      STROBE: begin
        if (ready_exit || limit_exit) begin
          state_next   = HOLD;
          rd_n_next    = 1'b1;
          wr_n_next    = 1'b1;
          done_next    = 1'b1;
          timeout_next = !ready_exit;
          if (!dir_wr_reg) begin
            rd_data_next = ready_exit ? inout_data : {DATA_WIDTH{1'b1}};
          end
        end else begin
          strobe_cnt_next = strobe_cnt_reg + CNT_ONE;
        end
      end

      HOLD: begin
        state_next   = IDLE;
        addr_oe_next = 1'b0;
        data_oe_next = 1'b0;
      end

      default: begin
        state_next   = IDLE;
        addr_oe_next = 1'b0;
        data_oe_next = 1'b0;
        rd_n_next    = 1'b1;
        wr_n_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      setup_cnt_reg  <= '0;
      strobe_cnt_reg <= '0;
      dir_wr_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rd_data_reg    <= '0;
      addr_oe_reg    <= 1'b0;
      data_oe_reg    <= 1'b0;
      rd_n_reg       <= 1'b1;
      wr_n_reg       <= 1'b1;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      perr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      setup_cnt_reg  <= setup_cnt_next;
      strobe_cnt_reg <= strobe_cnt_next;
      dir_wr_reg     <= dir_wr_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rd_data_reg    <= rd_data_next;
      addr_oe_reg    <= addr_oe_next;
      data_oe_reg    <= data_oe_next;
      rd_n_reg       <= rd_n_next;
      wr_n_reg       <= wr_n_next;
      done_reg       <= done_next;
      timeout_reg    <= timeout_next;
      perr_reg       <= perr_next;
    end
  end

  // Bus drivers are released by registered enables so they never glitch on.
  assign out_address  = addr_oe_reg ? addr_reg : {ADDR_WIDTH{1'bz}};
  assign inout_data   = data_oe_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
  assign out_rd_n     = rd_n_reg;
  assign out_wr_n     = wr_n_reg;
  assign rd_data      = rd_data_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign timeout      = timeout_reg;
  assign protocol_err = perr_reg;

endmodule

// File: tb/tb_io_bus_controller.sv
// Bench for io_bus_controller: timeline-based reference model checked every cycle,
// directed timing scenarios, randomized traffic, and an 8-bit/24-bit variant.
module tb_io_bus_controller;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int S   = 1;
  localparam int STB = 2;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          rd = 1'b0, wr = 1'b0, ext_ready = 1'b0;
  logic [AW-1:0] a_bus = '0;
  logic [DW-1:0] wr_data = '0, dev_data = '0;
  logic [DW-1:0] rd_data;
  logic          busy, done, timeout, protocol_err, out_rd_n, out_wr_n;
  wire  [AW-1:0] out_address;
  wire  [DW-1:0] inout_data;

  assign inout_data = (out_rd_n == 1'b0) ? dev_data : {DW{1'bz}};

  io_bus_controller u_dut (
    .clock(clk), .reset(reset), .rd(rd), .wr(wr), .a_bus(a_bus), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .timeout(timeout),
    .protocol_err(protocol_err), .out_address(out_address), .inout_data(inout_data),
    .out_rd_n(out_rd_n), .out_wr_n(out_wr_n), .ext_ready(ext_ready)
  );

  // Narrow-data, wide-address variant with a long setup and single-cycle strobe.
  logic        rd8 = 1'b0, wr8 = 1'b0, ext_ready8 = 1'b0;
  logic [23:0] a_bus8 = '0;
  logic [7:0]  wr_data8 = '0, dev_data8 = '0;
  logic [7:0]  rd_data8;
  logic        busy8, done8, timeout8, perr8, out_rd_n8, out_wr_n8;
  wire  [23:0] out_address8;
  wire  [7:0]  inout_data8;

  assign inout_data8 = (out_rd_n8 == 1'b0) ? dev_data8 : 8'bz;

  io_bus_controller #(
    .DATA_WIDTH(8), .ADDR_WIDTH(24), .SETUP_CYCLES(3), .STROBE_CYCLES(1), .TIMEOUT_CYCLES(64)
  ) u_dut8 (
    .clock(clk), .reset(reset), .rd(rd8), .wr(wr8), .a_bus(a_bus8), .wr_data(wr_data8),
    .rd_data(rd_data8), .busy(busy8), .done(done8), .timeout(timeout8),
    .protocol_err(perr8), .out_address(out_address8), .inout_data(inout_data8),
    .out_rd_n(out_rd_n8), .out_wr_n(out_wr_n8), .ext_ready(ext_ready8)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request is a timeline anchored on edge numbers.
  // Accept edge a -> strobe starts at edge a+S -> ends at the first edge te where
  // (te-ts >= STB and ready seen two edges earlier) or te-ts == TMO -> idle after te+1.
  int            n = 0;
  int            m_ts, m_te = -1, m_idle_from = 0, m_perr_at = -1;
  bit            m_active = 1'b0, m_wr = 1'b0, m_to = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  bit            hist [4];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active    = 1'b0;
      m_te        = -1;
      m_idle_from = 0;
      m_perr_at   = -1;
      m_rdata     = '0;
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    end else begin
      n = n + 1;
      hist[n % 4] = ext_ready;
      if (m_active) begin
        if (m_te < 0 && n > m_ts) begin
          if ((n - m_ts) >= STB && hist[(n + 2) % 4]) begin
            m_te = n; m_to = 1'b0;
          end else if ((n - m_ts) == TMO) begin
            m_te = n; m_to = 1'b1;
          end
          if (m_te == n && !m_wr) m_rdata = m_to ? {DW{1'b1}} : dev_data;
        end else if (m_te >= 0 && n == m_te + 1) begin
          m_active    = 1'b0;
          m_idle_from = n + 1;
        end
      end else if (n >= m_idle_from) begin
        if (rd ^ wr) begin
          m_active = 1'b1; m_wr = wr; m_addr = a_bus; m_wdata = wr_data;
          m_ts = n + S; m_te = -1;
        end else if (rd && wr) begin
          m_perr_at = n;
        end
      end
    end
  end

  bit strobing_e;
  bit addr_hiz;

  always @(negedge clk) begin
    if (chk_en) begin
      strobing_e = m_active && (n >= m_ts) && (m_te < 0);
      chk("busy", busy, m_active);
      chk("done", done, m_active && m_te == n);
      chk("timeout", timeout, m_active && m_te == n && m_to);
      chk("protocol_err", protocol_err, m_perr_at == n);
      chk("out_rd_n", out_rd_n, !(strobing_e && !m_wr));
      chk("out_wr_n", out_wr_n, !(strobing_e && m_wr));
      chk("rd_data", rd_data, m_rdata);
      if (m_active) begin
        chk("out_address", out_address, m_addr);
        if (m_wr) chk("write_bus", inout_data, m_wdata);
      end else begin
        addr_hiz = (out_address === {AW{1'bz}});
        chk("address_hiz", addr_hiz, 1'b1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_txn(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int raise_at, output int n_setup, output int n_strobe,
                         output int n_bad, output bit got_done, output bit got_to);
    n_setup = 0; n_strobe = 0; n_bad = 0; got_done = 1'b0; got_to = 1'b0;
    rd = !is_wr; wr = is_wr; a_bus = addr; wr_data = data;
    for (int c = 0; c < 200 && !got_done; c++) begin
      step();
      rd = 1'b0; wr = 1'b0;
      if (busy && out_rd_n && out_wr_n && n_strobe == 0 && !done) n_setup++;
      if (!out_rd_n || !out_wr_n) n_strobe++;
      if (is_wr && busy && inout_data !== data) n_bad++;
      if (raise_at != 0 && n_strobe == raise_at) ext_ready = 1'b1;
      if (done) begin got_done = 1'b1; got_to = timeout; end
    end
    step();
  endtask

  int ns, nst, nbad, cnt;
  bit gd, gt;
  int s8, st8;
  bit d8, to8;
  logic [23:0] addr8_seen;

  initial begin
    #1 reset = 1'b1;
    #2 chk_en = 1'b1;
    step(); step();
    reset = 1'b0;

    // Default write with device ready: 1 setup, 2 strobe cycles, data held on bus.
    ext_ready = 1'b1;
    step(); step(); step();
    bus_txn(1'b1, 16'h1234, 16'hBEEF, 0, ns, nst, nbad, gd, gt);
    chk("w_setup_cycles", ns, 1);
    chk("w_strobe_cycles", nst, 2);
    chk("w_done", gd, 1'b1);
    chk("w_timeout", gt, 1'b0);
    chk("w_bus_data_bad", nbad, 0);
    $display("txn write addr=1234 data=BEEF setup=%0d strobe=%0d done=%0d", ns, nst, gd);

    // Read stretched by late ready: raised during the 10th strobe cycle.
    ext_ready = 1'b0; dev_data = 16'h5A5A;
    step(); step(); step();
    bus_txn(1'b0, 16'h00FF, 16'h0000, 10, ns, nst, nbad, gd, gt);
    chk("r_strobe_cycles", nst, 12);
    chk("r_done", gd, 1'b1);
    chk("r_timeout", gt, 1'b0);
    chk("r_rd_data", rd_data, 16'h5A5A);
    $display("txn read addr=00FF strobe=%0d rd_data=%h", nst, rd_data);

    // Read with device never ready: full timeout.
    ext_ready = 1'b0; dev_data = 16'h1357;
    step(); step(); step();
    bus_txn(1'b0, 16'h0042, 16'h0000, 0, ns, nst, nbad, gd, gt);
    chk("to_strobe_cycles", nst, 64);
    chk("to_done", gd, 1'b1);
    chk("to_timeout", gt, 1'b1);
    chk("to_rd_data", rd_data, 16'hFFFF);
    $display("txn timeout-read strobe=%0d timeout=%0d rd_data=%h", nst, gt, rd_data);

    // Simultaneous rd and wr: one error pulse, no bus activity.
    rd = 1'b1; wr = 1'b1;
    step();
    rd = 1'b0; wr = 1'b0;
    cnt = 0; nbad = 0;
    for (int c = 0; c < 4; c++) begin
      if (protocol_err) cnt++;
      if (busy || !out_rd_n || !out_wr_n) nbad++;
      step();
    end
    chk("perr_pulses", cnt, 1);
    chk("perr_no_activity", nbad, 0);
    $display("txn rd+wr protocol_err pulses=%0d", cnt);

    // Reset asserted mid-strobe of a write.
    ext_ready = 1'b0;
    step(); step(); step();
    wr = 1'b1; a_bus = 16'h0BAD; wr_data = 16'hCAFE;
    nst = 0;
    for (int c = 0; c < 20 && nst < 3; c++) begin
      step();
      wr = 1'b0;
      if (!out_wr_n) nst++;
    end
    chk("rst_reached_strobe", nst, 3);
    #1 reset = 1'b1;
    #1;
    addr_hiz = (out_address === {AW{1'bz}});
    chk("rst_wr_n_high", out_wr_n, 1'b1);
    chk("rst_rd_n_high", out_rd_n, 1'b1);
    chk("rst_busy_low", busy, 1'b0);
    chk("rst_addr_hiz", addr_hiz, 1'b1);
    step(); step();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) cnt++;
      step();
    end
    chk("rst_no_done", cnt, 0);
    ext_ready = 1'b1;
    step(); step(); step();
    bus_txn(1'b1, 16'h00A5, 16'h5AA5, 0, ns, nst, nbad, gd, gt);
    chk("post_rst_strobe", nst, 2);
    chk("post_rst_done", gd, 1'b1);
    $display("txn reset-abort then write strobe=%0d done=%0d", nst, gd);

    // Randomized traffic with varying ready behaviour and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 250; c++) begin
        step();
        rd = 1'b0; wr = 1'b0;
        case ($urandom_range(0, 9))
          0, 1: rd = 1'b1;
          2, 3: wr = 1'b1;
          4: begin rd = 1'b1; wr = 1'b1; end
          default: ;
        endcase
        a_bus = AW'($urandom); wr_data = DW'($urandom); dev_data = DW'($urandom);
        case (mode)
          0: if ($urandom_range(0, 5) == 0) ext_ready = !ext_ready;
          1: ext_ready = 1'b0;
          default: ext_ready = 1'b1;
        endcase
        if ($urandom_range(0, 399) == 0) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
        end
      end
      $display("random block %0d mode=%0d checks=%0d", blk, mode, checks);
    end
    rd = 1'b0; wr = 1'b0;
    for (int c = 0; c < 80; c++) step();

    // 8-bit data / 24-bit address variant read.
    ext_ready8 = 1'b1;
    step(); step(); step();
    rd8 = 1'b1; a_bus8 = 24'hABCDEF; dev_data8 = 8'hC3;
    s8 = 0; st8 = 0; d8 = 1'b0; to8 = 1'b0; addr8_seen = '0;
    for (int c = 0; c < 50 && !d8; c++) begin
      step();
      rd8 = 1'b0;
      if (busy8 && out_rd_n8 && out_wr_n8 && st8 == 0 && !done8) s8++;
      if (!out_rd_n8) begin st8++; addr8_seen = out_address8; end
      if (done8) begin d8 = 1'b1; to8 = timeout8; end
    end
    chk("w8_setup_cycles", s8, 3);
    chk("w8_strobe_cycles", st8, 1);
    chk("w8_done", d8, 1'b1);
    chk("w8_timeout", to8, 1'b0);
    chk("w8_address", addr8_seen, 24'hABCDEF);
    chk("w8_rd_data", rd_data8, 8'hC3);
    chk("w8_perr", perr8, 1'b0);
    $display("txn narrow read addr=ABCDEF setup=%0d strobe=%0d rd_data=%h", s8, st8, rd_data8);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
